// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small decode helpers.
package mdu_pkg;

    localparam logic [1:0] MDOP_MULT  = 2'b00;
    localparam logic [1:0] MDOP_MULTU = 2'b01;
    localparam logic [1:0] MDOP_DIV   = 2'b10;
    localparam logic [1:0] MDOP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation: a multiply negates the full double-width
// product, a divide negates quotient and remainder independently.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             neg_hi_i,
    input  logic             neg_lo_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] wide_neg;

    assign wide_neg = -{hi_i, lo_i};

    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        if (!op_is_div(op_i)) begin
            // For a product the sign lives in neg_lo_i and spans both halves.
            if (neg_lo_i) begin
                {hi_o, lo_o} = wide_neg;
            end
        end else begin
            if (neg_hi_i) begin
                hi_o = -hi_i;
            end
            if (neg_lo_i) begin
                lo_o = -lo_i;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, signs applied once at the end.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [1:0]       MDOP,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic               neg_hi_q;
    logic               neg_lo_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               divbyzero_q;

    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    assign sign1 = op_is_signed(MDOP) & In1[WIDTH-1];
    assign sign2 = op_is_signed(MDOP) & In2[WIDTH-1];

    // Same negator turns raw operands into magnitudes; the most-negative value
    // maps to 2**(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs (
        .hi_i     (In1),
        .lo_i     (In2),
        .neg_hi_i (sign1),
        .neg_lo_i (sign2),
        .op_i     (MDOP_DIV),
        .hi_o     (abs1),
        .lo_o     (abs2)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .hi_i     (acc_q[2*WIDTH-1:WIDTH]),
        .lo_i     (acc_q[WIDTH-1:0]),
        .neg_hi_i (neg_hi_q),
        .neg_lo_i (neg_lo_q),
        .op_i     (op_q),
        .hi_o     (fix_hi),
        .lo_o     (fix_lo)
    );

    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = shifted - {1'b0, mcand_q};
        if (op_is_div(op_q)) begin
            // Upper half is the partial remainder, lower half shifts dividend out / quotient in.
            acc_d = diff[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= MDOP_MULT;
            mcand_q     <= '0;
            acc_q       <= '0;
            neg_hi_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            dbz_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            divbyzero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start && !Flush) begin
                        op_q     <= MDOP;
                        cnt_q    <= CNT_W'(WIDTH);
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                        neg_lo_q <= sign1 ^ sign2;
                        neg_hi_q <= sign1;
                        dbz_q    <= op_is_div(MDOP) && (In2 == '0);
                        if (op_is_div(MDOP)) begin
                            mcand_q <= abs2;
                            acc_q   <= {{WIDTH{1'b0}}, abs1};
                        end else begin
                            mcand_q <= abs1;
                            acc_q   <= {{WIDTH{1'b0}}, abs2};
                        end
                    end
                end
                CALC: begin
                    if (Flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (Flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        // Divide-by-zero: remainder path already reproduces In1; quotient forced to all ones.
                        hi_q        <= fix_hi;
                        lo_q        <= dbz_q ? '1 : fix_lo;
                        divbyzero_q <= dbz_q;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign DivByZero = divbyzero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed scenarios plus
// randomized operations against an arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Start = 1'b0;
    logic         Flush = 1'b0;
    logic [1:0]   MDOP = 2'b00;
    logic [W-1:0] In1 = '0;
    logic [W-1:0] In2 = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         DivByZero;

    int passed = 0;
    int total  = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .MDOP      (MDOP),
        .In1       (In1),
        .In2       (In2),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .HI        (HI),
        .LO        (LO),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic with MIPS divide rules.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            MDOP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = sp;
            end
            MDOP_MULTU: begin
                up = 64'(a) * 64'(b);
                {hi, lo} = up;
            end
            MDOP_DIV: begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hi = 32'h0; lo = 32'h8000_0000;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    hi = r; lo = q;
                end
            end
            default: begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else begin
                    hi = a % b; lo = a / b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called right after a negedge; returns at the negedge following the accepting edge E0.
    task automatic pulse_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        MDOP  = op;
        In1   = a;
        In2   = b;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // lat = number of edges after E0 until Done is seen; busy_bad counts cycles without Busy before that.
    task automatic wait_done(output int lat, output int busy_bad);
        lat = 0;
        busy_bad = 0;
        while (Done !== 1'b1 && lat < 100) begin
            if (Busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (Done === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (HI !== 32'h0) $display("FAIL reset_hi: got %h want 00000000", HI); else passed++;
        total++; if (LO !== 32'h0) $display("FAIL reset_lo: got %h want 00000000", LO); else passed++;
        total++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else passed++;
        total++; if (Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Done); else passed++;
        total++; if (DivByZero !== 1'b0) $display("FAIL reset_dbz: got %b want 0", DivByZero); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (Busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", Busy); else passed++;
    endtask

    task automatic test_multu_timing();
        int lat, bb;
        pulse_start(MDOP_MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_done(lat, bb);
        $display("MULTU ffffffff*2 -> HI=%h LO=%h lat=%0d", HI, LO, lat);
        total++; if (lat !== 33) $display("FAIL multu_latency: got %0d want 33", lat); else passed++;
        total++; if (bb !== 0) $display("FAIL multu_busy_gap: got %0d cycles without Busy want 0", bb); else passed++;
        total++; if (Busy !== 1'b0) $display("FAIL multu_busy_at_done: got %b want 0", Busy); else passed++;
        total++; if (HI !== 32'h1) $display("FAIL multu_hi: got %h want 00000001", HI); else passed++;
        total++; if (LO !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h want fffffffe", LO); else passed++;
        total++; if (DivByZero !== 1'b0) $display("FAIL multu_dbz: got %b want 0", DivByZero); else passed++;
        @(negedge clk);
        total++; if (Done !== 1'b0) $display("FAIL multu_done_pulse: got %b want 0", Done); else passed++;
        repeat (3) @(negedge clk);
        total++; if (LO !== 32'hFFFF_FFFE) $display("FAIL multu_lo_hold: got %h want fffffffe", LO); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, bb;
        pulse_start(MDOP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, bb);
        $display("MULT -3*7 -> HI=%h LO=%h lat=%0d", HI, LO, lat);
        total++; if (HI !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi: got %h want ffffffff", HI); else passed++;
        total++; if (LO !== 32'hFFFF_FFEB) $display("FAIL mult_neg_lo: got %h want ffffffeb", LO); else passed++;
        pulse_start(MDOP_DIV, 32'hFFFF_FFF9, 32'd2);
        total++; if (Busy !== 1'b1 || Done !== 1'b0) $display("FAIL b2b_accept: got Busy=%b Done=%b want 1 0", Busy, Done); else passed++;
        wait_done(lat, bb);
        $display("DIV -7/2 -> HI=%h LO=%h lat=%0d", HI, LO, lat);
        total++; if (lat !== 33) $display("FAIL b2b_latency: got %0d want 33", lat); else passed++;
        total++; if (LO !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo: got %h want fffffffd", LO); else passed++;
        total++; if (HI !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi: got %h want ffffffff", HI); else passed++;
    endtask

    task automatic test_div_by_zero();
        int lat, bb;
        logic [31:0] eh, el;
        logic ed;
        pulse_start(MDOP_DIVU, 32'd10, 32'd0);
        wait_done(lat, bb);
        $display("DIVU 10/0 -> HI=%h LO=%h dbz=%b lat=%0d", HI, LO, DivByZero, lat);
        total++; if (lat !== 33) $display("FAIL dbz_latency: got %0d want 33", lat); else passed++;
        total++; if (DivByZero !== 1'b1) $display("FAIL dbz_flag: got %b want 1", DivByZero); else passed++;
        total++; if (LO !== 32'hFFFF_FFFF) $display("FAIL dbz_lo: got %h want ffffffff", LO); else passed++;
        total++; if (HI !== 32'h0000_000A) $display("FAIL dbz_hi: got %h want 0000000a", HI); else passed++;
        repeat (4) @(negedge clk);
        total++; if (DivByZero !== 1'b1) $display("FAIL dbz_hold: got %b want 1", DivByZero); else passed++;
        pulse_start(MDOP_DIVU, 32'd10, 32'd3);
        wait_done(lat, bb);
        $display("DIVU 10/3 -> HI=%h LO=%h dbz=%b", HI, LO, DivByZero);
        total++; if (LO !== 32'd3) $display("FAIL divu_lo: got %h want 00000003", LO); else passed++;
        total++; if (HI !== 32'd1) $display("FAIL divu_hi: got %h want 00000001", HI); else passed++;
        total++; if (DivByZero !== 1'b0) $display("FAIL divu_dbz_clear: got %b want 0", DivByZero); else passed++;
        ref_model(MDOP_DIV, 32'hFFFF_FFF6, 32'd0, eh, el, ed);
        pulse_start(MDOP_DIV, 32'hFFFF_FFF6, 32'd0);
        wait_done(lat, bb);
        $display("DIV -10/0 -> HI=%h LO=%h dbz=%b", HI, LO, DivByZero);
        total++; if (HI !== eh || LO !== el || DivByZero !== ed) $display("FAIL sdbz: got %h %h %b want %h %h %b", HI, LO, DivByZero, eh, el, ed); else passed++;
    endtask

    task automatic test_overflow();
        int lat, bb;
        pulse_start(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bb);
        $display("DIV 80000000/ffffffff -> HI=%h LO=%h dbz=%b", HI, LO, DivByZero);
        total++; if (LO !== 32'h8000_0000) $display("FAIL ovf_lo: got %h want 80000000", LO); else passed++;
        total++; if (HI !== 32'h0) $display("FAIL ovf_hi: got %h want 00000000", HI); else passed++;
        total++; if (DivByZero !== 1'b0) $display("FAIL ovf_dbz: got %b want 0", DivByZero); else passed++;
        pulse_start(MDOP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat, bb);
        $display("MULT 80000000*80000000 -> HI=%h LO=%h", HI, LO);
        total++; if (HI !== 32'h4000_0000) $display("FAIL mneg_hi: got %h want 40000000", HI); else passed++;
        total++; if (LO !== 32'h0) $display("FAIL mneg_lo: got %h want 00000000", LO); else passed++;
    endtask

    task automatic test_flush();
        int lat, bb, n;
        pulse_start(MDOP_MULTU, 32'd5, 32'd5);
        wait_done(lat, bb);
        $display("MULTU 5*5 -> HI=%h LO=%h", HI, LO);
        total++; if (LO !== 32'd25) $display("FAIL flush_pre_lo: got %0d want 25", LO); else passed++;
        pulse_start(MDOP_MULT, 32'd3, 32'd3);
        repeat (9) @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        $display("MULT 3*3 flushed at E0+10 -> Busy=%b LO=%h", Busy, LO);
        total++; if (Busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", Busy); else passed++;
        total++; if (Done !== 1'b0) $display("FAIL flush_done: got %b want 0", Done); else passed++;
        count_dones(40, n);
        total++; if (n !== 0) $display("FAIL flush_no_done: got %0d pulses want 0", n); else passed++;
        total++; if (LO !== 32'd25 || HI !== 32'h0) $display("FAIL flush_hold: got %h %h want 00000000 00000019", HI, LO); else passed++;
        MDOP = MDOP_MULTU; In1 = 32'd9; In2 = 32'd9;
        Start = 1'b1; Flush = 1'b1;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        $display("Start+Flush in idle -> Busy=%b", Busy);
        total++; if (Busy !== 1'b0) $display("FAIL flush_idle_busy: got %b want 0", Busy); else passed++;
        count_dones(40, n);
        total++; if (n !== 0 || LO !== 32'd25) $display("FAIL flush_idle_drop: got %0d pulses LO=%0d want 0 pulses LO=25", n, LO); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat, bb, n;
        pulse_start(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bb);
        pulse_start(MDOP_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-CALC -> HI=%h LO=%h Busy=%b", HI, LO, Busy);
        total++; if (HI !== 32'h0 || LO !== 32'h0) $display("FAIL rstmid_hilo: got %h %h want 0 0", HI, LO); else passed++;
        total++; if (Busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", Busy); else passed++;
        count_dones(40, n);
        total++; if (n !== 0) $display("FAIL rstmid_no_done: got %0d pulses want 0", n); else passed++;
    endtask

    task automatic test_start_ignored();
        int lat, bb, n;
        pulse_start(MDOP_MULTU, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        MDOP = MDOP_DIV; In1 = 32'd77; In2 = 32'd5;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        wait_done(lat, bb);
        $display("MULTU 1000*3 with restart at E0+5 -> HI=%h LO=%h lat=%0d", HI, LO, lat + 5);
        total++; if (lat + 5 !== 33) $display("FAIL ign_latency: got %0d want 33", lat + 5); else passed++;
        total++; if (HI !== 32'h0 || LO !== 32'd3000) $display("FAIL ign_result: got %h %h want 00000000 00000bb8", HI, LO); else passed++;
        count_dones(40, n);
        total++; if (n !== 0) $display("FAIL ign_extra_done: got %0d extra pulses want 0", n); else passed++;
    endtask

    task automatic test_random();
        int lat, bb;
        logic [1:0] op;
        logic [31:0] a, b, eh, el;
        logic ed;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            ref_model(op, a, b, eh, el, ed);
            pulse_start(op, a, b);
            // Scribble on the inputs while busy; the result must not care.
            In1 = $urandom; In2 = $urandom; MDOP = 2'($urandom_range(0, 3));
            wait_done(lat, bb);
            $display("rnd%0d op=%0d a=%h b=%h -> HI=%h LO=%h dbz=%b lat=%0d", i, op, a, b, HI, LO, DivByZero, lat);
            total++; if (HI !== eh) $display("FAIL rnd_hi[%0d]: got %h want %h", i, HI, eh); else passed++;
            total++; if (LO !== el) $display("FAIL rnd_lo[%0d]: got %h want %h", i, LO, el); else passed++;
            total++; if (DivByZero !== ed) $display("FAIL rnd_dbz[%0d]: got %b want %b", i, DivByZero, ed); else passed++;
            total++; if (lat !== 33 || bb !== 0) $display("FAIL rnd_timing[%0d]: got lat=%0d gaps=%0d want 33 0", i, lat, bb); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_multu_timing();
        test_back_to_back();
        test_div_by_zero();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached after %0d/%0d checks", passed, total);
        $fatal(1);
    end

endmodule
